// File: rtl/dual_issue_scheduler.sv
// Dual-issue ID-stage issue controller: combines forwarding readiness with a
// per-register scoreboard of in-flight long-latency writers and serializes issue-alone ops.
module dual_issue_scheduler #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ex_allowin,
  input  logic            pipe_empty,
  input  logic            l1_valid,
  input  logic            l2_valid,
  input  logic            l1_re1,
  input  logic            l1_re2,
  input  logic            l2_re1,
  input  logic            l2_re2,
  input  logic [AW-1:0]   l1_raddr1,
  input  logic [AW-1:0]   l1_raddr2,
  input  logic [AW-1:0]   l2_raddr1,
  input  logic [AW-1:0]   l2_raddr2,
  input  logic            l1_we,
  input  logic            l2_we,
  input  logic [AW-1:0]   l1_waddr,
  input  logic [AW-1:0]   l2_waddr,
  input  logic            l1_long,
  input  logic            l2_long,
  input  logic            l1_serial,
  input  logic            l2_serial,
  input  logic            l1_fwd_ready,
  input  logic            l2_fwd_ready,
  input  logic            wb1_clr,
  input  logic            wb2_clr,
  input  logic [AW-1:0]   wb1_waddr,
  input  logic [AW-1:0]   wb2_waddr,
  output logic            issue1,
  output logic            issue2,
  output logic            drain,
  output logic [NREG-1:0] sb_busy,
  output logic            sb_err
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW+1:0]   CNT_MAX_W = {2'b00, CNT_MAX};

  state_e        state, state_nxt;
  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic          err_set;

  logic hz1, hz2, l1_lw, l2_lw, raw, waw, all_zero;
  logic run_ok1, pair_ok, drain_ok, inc1, inc2;

  always_comb begin
    for (int r = 0; r < NREG; r++) sb_busy[r] = (cnt[r] != '0);
  end

  // sb_busy[0] is always 0, so indexing it also covers the "nonzero address" rule.
  assign hz1 = (l1_re1 && sb_busy[l1_raddr1]) || (l1_re2 && sb_busy[l1_raddr2]);
  assign hz2 = (l2_re1 && sb_busy[l2_raddr1]) || (l2_re2 && sb_busy[l2_raddr2]);

  assign l1_lw    = l1_long && l1_we && (l1_waddr != '0);
  assign l2_lw    = l2_long && l2_we && (l2_waddr != '0);
  assign all_zero = (sb_busy == '0);

  assign raw = l1_we && (l1_waddr != '0) &&
               ((l2_re1 && (l2_raddr1 == l1_waddr)) || (l2_re2 && (l2_raddr2 == l1_waddr)));
  assign waw = l1_we && l2_we && (l1_waddr != '0) && (l1_waddr == l2_waddr);

  assign run_ok1 = l1_valid && l1_fwd_ready && !hz1 && ex_allowin && !flush && !l1_serial &&
                   (!l1_lw || (cnt[l1_waddr] != CNT_MAX));
  assign pair_ok = l2_valid && !l2_serial && l2_fwd_ready && !hz2 && !raw && !waw &&
                   (!l2_lw || (cnt[l2_waddr] != CNT_MAX));
  assign drain_ok = l1_valid && pipe_empty && all_zero && ex_allowin && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (l1_valid && l1_serial) state_nxt = DRAIN;
        DRAIN:   if (drain_ok)              state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs are gated by rst_n so nothing issues while reset is held.
  always_comb begin
    issue1 = 1'b0;
    issue2 = 1'b0;
    drain  = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          issue1 = run_ok1;
          issue2 = run_ok1 && pair_ok;
        end
        DRAIN: begin
          drain  = 1'b1;
          issue1 = drain_ok;
        end
        default: ;
      endcase
    end
  end

  assign inc1 = issue1 && l1_lw;
  assign inc2 = issue2 && l2_lw;

  always_comb begin
    logic          inc;
    logic [1:0]    dec;
    logic [CW+1:0] up, dn, df;
    err_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc = 1'b0;
      dec = '0;
      up  = '0;
      dn  = '0;
      df  = '0;
      cnt_nxt[r] = cnt[r];
      if (r != 0) begin
        inc = (inc1 && (l1_waddr == AW'(r))) || (inc2 && (l2_waddr == AW'(r)));
        dec = {1'b0, wb1_clr && (wb1_waddr == AW'(r))} + {1'b0, wb2_clr && (wb2_waddr == AW'(r))};
        up  = {2'b00, cnt[r]} + {{(CW+1){1'b0}}, inc};
        dn  = {{CW{1'b0}}, dec};
        if (up < dn) begin
          cnt_nxt[r] = '0;
          err_set    = 1'b1;
        end else begin
          df = up - dn;
          if (df > CNT_MAX_W) begin
            cnt_nxt[r] = CNT_MAX;
            err_set    = 1'b1;
          end else begin
            cnt_nxt[r] = df[CW-1:0];
          end
        end
      end
    end
  end

  // NOTE: the counter array is reset explicitly; a scoreboard that powers up
  // with stale pending writers would block issue forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (err_set) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed self-checking bench for dual_issue_scheduler: issue rules, scoreboard
// latency, saturation, serial drain, flush and sticky error behaviour.
module tb_dual_issue_scheduler;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;

  logic clk, rst_n, flush, ex_allowin, pipe_empty;
  logic l1_valid, l2_valid, l1_re1, l1_re2, l2_re1, l2_re2;
  logic [AW-1:0] l1_raddr1, l1_raddr2, l2_raddr1, l2_raddr2;
  logic l1_we, l2_we;
  logic [AW-1:0] l1_waddr, l2_waddr;
  logic l1_long, l2_long, l1_serial, l2_serial, l1_fwd_ready, l2_fwd_ready;
  logic wb1_clr, wb2_clr;
  logic [AW-1:0] wb1_waddr, wb2_waddr;
  logic issue1, issue2, drain, sb_err;
  logic [NREG-1:0] sb_busy;

  int checks   = 0;
  int failures = 0;

  dual_issue_scheduler #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_allowin(ex_allowin), .pipe_empty(pipe_empty),
    .l1_valid(l1_valid), .l2_valid(l2_valid),
    .l1_re1(l1_re1), .l1_re2(l1_re2), .l2_re1(l2_re1), .l2_re2(l2_re2),
    .l1_raddr1(l1_raddr1), .l1_raddr2(l1_raddr2), .l2_raddr1(l2_raddr1), .l2_raddr2(l2_raddr2),
    .l1_we(l1_we), .l2_we(l2_we), .l1_waddr(l1_waddr), .l2_waddr(l2_waddr),
    .l1_long(l1_long), .l2_long(l2_long), .l1_serial(l1_serial), .l2_serial(l2_serial),
    .l1_fwd_ready(l1_fwd_ready), .l2_fwd_ready(l2_fwd_ready),
    .wb1_clr(wb1_clr), .wb2_clr(wb2_clr), .wb1_waddr(wb1_waddr), .wb2_waddr(wb2_waddr),
    .issue1(issue1), .issue2(issue2), .drain(drain), .sb_busy(sb_busy), .sb_err(sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval();
    #2;
  endtask

  task automatic l1_set(input logic we, input int wa, input logic re1, input int ra1,
                        input logic re2, input int ra2, input logic lng, input logic ser);
    l1_valid = 1'b1; l1_we = we; l1_waddr = AW'(wa);
    l1_re1 = re1; l1_raddr1 = AW'(ra1); l1_re2 = re2; l1_raddr2 = AW'(ra2);
    l1_long = lng; l1_serial = ser;
  endtask

  task automatic l2_set(input logic we, input int wa, input logic re1, input int ra1,
                        input logic re2, input int ra2, input logic lng, input logic ser);
    l2_valid = 1'b1; l2_we = we; l2_waddr = AW'(wa);
    l2_re1 = re1; l2_raddr1 = AW'(ra1); l2_re2 = re2; l2_raddr2 = AW'(ra2);
    l2_long = lng; l2_serial = ser;
  endtask

  task automatic idle();
    flush = 1'b0; ex_allowin = 1'b1; pipe_empty = 1'b0;
    l1_valid = 1'b0; l2_valid = 1'b0;
    l1_re1 = 1'b0; l1_re2 = 1'b0; l2_re1 = 1'b0; l2_re2 = 1'b0;
    l1_raddr1 = '0; l1_raddr2 = '0; l2_raddr1 = '0; l2_raddr2 = '0;
    l1_we = 1'b0; l2_we = 1'b0; l1_waddr = '0; l2_waddr = '0;
    l1_long = 1'b0; l2_long = 1'b0; l1_serial = 1'b0; l2_serial = 1'b0;
    l1_fwd_ready = 1'b1; l2_fwd_ready = 1'b1;
    wb1_clr = 1'b0; wb2_clr = 1'b0; wb1_waddr = '0; wb2_waddr = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    l1_set(1, 4, 1, 1, 1, 2, 0, 0);
    eval();
    check("rst_issue1", 32'(issue1), 0);
    check("rst_drain", 32'(drain), 0);
    check("rst_busy", sb_busy, 0);
    check("rst_err", 32'(sb_err), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Independent pair
    idle();
    l1_set(1, 4, 1, 1, 1, 2, 0, 0);
    l2_set(1, 5, 1, 3, 1, 6, 0, 0);
    eval();
    check("pair_issue1", 32'(issue1), 1);
    check("pair_issue2", 32'(issue2), 1);
    tick();
    ex_allowin = 1'b0;
    eval();
    check("noallow_issue1", 32'(issue1), 0);
    check("noallow_issue2", 32'(issue2), 0);
    check("pair_busy", sb_busy, 0);
    tick();
    ex_allowin = 1'b1; flush = 1'b1;
    eval();
    check("flush_run_issue1", 32'(issue1), 0);
    tick();

    // Load then consumer
    idle();
    l1_set(1, 7, 1, 1, 0, 0, 1, 0);
    eval();
    check("ld_issue", 32'(issue1), 1);
    tick();
    l1_set(1, 8, 1, 7, 0, 0, 0, 0);
    eval();
    check("use_blocked", 32'(issue1), 0);
    check("use_busy7", sb_busy, 32'h80);
    tick();
    l1_re1 = 1'b0;
    eval();
    check("use_re_off", 32'(issue1), 1);
    tick();
    l1_re1 = 1'b1; wb1_clr = 1'b1; wb1_waddr = 5'd7;
    eval();
    check("use_clr_cycle", 32'(issue1), 0);
    tick();
    wb1_clr = 1'b0;
    eval();
    check("use_unblocked", 32'(issue1), 1);
    check("use_busy_clear", sb_busy, 0);
    tick();

    // Long write to r0 is never tracked
    l1_set(1, 0, 1, 1, 0, 0, 1, 0);
    tick();
    idle();
    eval();
    check("r0_untracked", sb_busy, 0);
    tick();

    // Intra-pair RAW / WAW
    l1_set(1, 9, 1, 1, 0, 0, 0, 0);
    l2_set(1, 10, 1, 9, 0, 0, 0, 0);
    eval();
    check("raw_issue1", 32'(issue1), 1);
    check("raw_issue2", 32'(issue2), 0);
    tick();
    l1_waddr = 5'd0;
    eval();
    check("raw_r0_issue2", 32'(issue2), 1);
    tick();
    l1_set(1, 11, 1, 1, 0, 0, 0, 0);
    l2_set(1, 11, 1, 3, 0, 0, 0, 0);
    eval();
    check("waw_issue2", 32'(issue2), 0);
    tick();

    // Counter saturation on r13
    idle();
    for (int i = 0; i < 3; i++) begin
      l1_set(1, 13, 1, 1, 0, 0, 1, 0);
      eval();
      check($sformatf("sat_ld%0d", i), 32'(issue1), 1);
      tick();
    end
    eval();
    check("sat_busy", sb_busy, 32'h2000);
    check("sat_blocked", 32'(issue1), 0);
    tick();
    idle();
    wb1_clr = 1'b1; wb1_waddr = 5'd13; wb2_clr = 1'b1; wb2_waddr = 5'd13;
    tick();
    wb2_clr = 1'b0;
    eval();
    check("sat_cnt1_busy", sb_busy, 32'h2000);
    tick();
    wb1_clr = 1'b0;
    eval();
    check("sat_drained", sb_busy, 0);
    check("sat_no_err", 32'(sb_err), 0);
    tick();

    // Dual long pair then double clear of r2 at count 2
    l1_set(1, 2, 1, 1, 0, 0, 1, 0);
    l2_set(1, 3, 1, 4, 0, 0, 1, 0);
    eval();
    check("dl_issue2", 32'(issue2), 1);
    tick();
    l2_valid = 1'b0;
    eval();
    check("dl_again", 32'(issue1), 1);
    tick();
    idle();
    eval();
    check("dl_busy", sb_busy, 32'h0c);
    wb1_clr = 1'b1; wb1_waddr = 5'd2; wb2_clr = 1'b1; wb2_waddr = 5'd2;
    tick();
    idle();
    eval();
    check("dbl_clr_busy", sb_busy, 32'h08);
    check("dbl_clr_err", 32'(sb_err), 0);
    tick();

    // Serial instruction with r3 busy
    l1_set(0, 0, 0, 0, 0, 0, 0, 1);
    eval();
    check("ser_run_issue", 32'(issue1), 0);
    check("ser_run_drain", 32'(drain), 0);
    tick();
    eval();
    check("ser_drain", 32'(drain), 1);
    check("ser_wait_issue", 32'(issue1), 0);
    tick();
    pipe_empty = 1'b1; wb1_clr = 1'b1; wb1_waddr = 5'd3;
    eval();
    check("ser_busy_block", 32'(issue1), 0);
    tick();
    wb1_clr = 1'b0;
    l2_set(1, 5, 1, 1, 0, 0, 0, 0);
    eval();
    check("ser_go_issue1", 32'(issue1), 1);
    check("ser_go_issue2", 32'(issue2), 0);
    check("ser_go_drain", 32'(drain), 1);
    tick();
    idle();
    eval();
    check("ser_done_drain", 32'(drain), 0);
    check("ser_done_issue", 32'(issue1), 0);
    tick();

    // Flush mid-DRAIN with r3 and r7 busy
    l1_set(1, 3, 1, 1, 0, 0, 1, 0);
    l2_set(1, 7, 1, 2, 0, 0, 1, 0);
    eval();
    check("fl_pair_issue2", 32'(issue2), 1);
    tick();
    idle();
    l1_set(0, 0, 0, 0, 0, 0, 0, 1);
    eval();
    check("fl_busy", sb_busy, 32'h88);
    tick();
    flush = 1'b1;
    eval();
    check("fl_in_drain", 32'(drain), 1);
    check("fl_no_issue", 32'(issue1), 0);
    tick();
    idle();
    eval();
    check("fl_drain_off", 32'(drain), 0);
    check("fl_busy_clear", sb_busy, 0);
    tick();

    // Underflow is sticky
    wb1_clr = 1'b1; wb1_waddr = 5'd12;
    tick();
    wb1_clr = 1'b0;
    eval();
    check("uf_err", 32'(sb_err), 1);
    check("uf_busy", sb_busy, 0);
    tick(); tick(); tick();
    eval();
    check("uf_sticky", 32'(sb_err), 1);
    tick();

    // Reset mid-DRAIN
    l1_set(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    eval();
    check("rd_drain", 32'(drain), 1);
    rst_n = 1'b0;
    #1;
    check("rd_rst_drain", 32'(drain), 0);
    check("rd_rst_issue", 32'(issue1), 0);
    check("rd_rst_err", 32'(sb_err), 0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    eval();
    check("rd_run", 32'(drain), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
